// File: rtl/noc_pkt_injector.sv
// noc_pkt_injector
//   Clocked transmitter for an 8-bit NoC injection (dg) channel.
//   - Packets arrive over valid/ready and are stored in a small FIFO.
//   - Each packet is sent to the node with a 4-phase return-to-zero,
//     bundled-data handshake on tx_req/tx_ack.
//   - tx_ack is asynchronous and passes through a SYNC_STAGES-deep
//     synchronizer before the FSM looks at it.
//   - Optional feature macro NOC_SELF_DROP_EN: a packet whose destination
//     field equals MY_IP is discarded in IDLE without a handshake and
//     counted on drop_cnt.
module noc_pkt_injector #(
    parameter int          WIDTH       = 8,
    parameter int          DEPTH       = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [3:0]  MY_IP       = 4'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ack,
    output logic             busy,
    output logic [15:0]      sent_cnt
`ifdef NOC_SELF_DROP_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers (one extra wrap bit each)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop in the same cycle does not open a full FIFO: no pass-through.
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem[rd_ptr[AW-1:0]];

    // ------------------------------------------------------------------
    // Acknowledge synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // Shift the raw acknowledge through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples values from before the edge.
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], tx_ack};
        end
    end

    // ------------------------------------------------------------------
    // Destination match for the optional self-drop feature
    // ------------------------------------------------------------------
    logic self_dest;

`ifdef NOC_SELF_DROP_EN
    assign self_dest = (head[WIDTH-1 -: 4] == MY_IP);
`else
    // Without self-drop every packet is transmitted; MY_IP has no role.
    logic unused_my_ip;
    assign unused_my_ip = ^MY_IP;
    assign self_dest    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   req_next;
    logic   load_tx;
    logic   sent_inc;
    logic   drop;

    // Next-state, pop and counter-increment decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        req_next   = 1'b0;
        pop        = 1'b0;
        load_tx    = 1'b0;
        sent_inc   = 1'b0;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                // Acknowledge is ignored here; only FIFO occupancy matters.
                if (!empty) begin
                    pop = 1'b1;
                    if (self_dest) begin
                        drop = 1'b1;
                    end else begin
                        load_tx    = 1'b1;
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                // Data has been stable for a full cycle; raise the request.
                state_next = REQ_HI;
                req_next   = 1'b1;
            end
            REQ_HI: begin
                req_next = 1'b1;
                if (ack_s) begin
                    state_next = REQ_LO;
                    req_next   = 1'b0;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    sent_inc = 1'b1;
                    // Chain straight into the next packet when possible; a
                    // self-addressed head goes back to IDLE to be dropped.
                    if (!empty && !self_dest) begin
                        pop        = 1'b1;
                        load_tx    = 1'b1;
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus registered request and bundled data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_req  <= 1'b0;
            tx_data <= '0;
        end else begin
            state  <= state_next;
            tx_req <= req_next;
            if (load_tx) begin
                tx_data <= head;
            end
        end
    end

    // FIFO write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the pointers define which
        // entries are valid, so clearing the array would only cost logic.
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Completed-handshake counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt <= '0;
        end else if (sent_inc) begin
            sent_cnt <= sent_cnt + 16'd1;
        end
    end

`ifdef NOC_SELF_DROP_EN
    // Count packets discarded because they were addressed to this node.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    assign busy = !empty || (state != IDLE);

endmodule
